fn_division_seq: RTL and testbench

FN_DIVISION_SEQ -- requirements
Module: fn_division_seq

---
 rtl/fn_division_seq.sv | 152 +++++++++++++++
 tb/tb_fn_division_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fn_division_seq.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency of ANCHO+1 cycles.
// Optional macro FN_DIV_SIGNO_EN compiles in signed division (DIV/REM) selected by signo.
module fn_division_seq #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic             signo,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] resto
);

    localparam int CW = $clog2(ANCHO + 1);

    typedef enum logic [1:0] {
        REPOSO,
        CALCULO,
        AJUSTE
    } estado_t;

    estado_t          estado, estado_sig;
    logic [CW-1:0]    cuenta, cuenta_sig;
    logic [ANCHO-1:0] dividendo, dividendo_sig;   // dividend bits shift out, quotient bits shift in
    logic [ANCHO-1:0] divisor, divisor_sig;
    logic [ANCHO-1:0] parcial, parcial_sig;
    logic             ocupado_sig, listo_sig;
    logic [ANCHO-1:0] cociente_sig, resto_sig;
    logic [ANCHO-1:0] mag_a, mag_b;

    logic [ANCHO:0]   tanteo;
    logic [ANCHO+1:0] dif;
    logic             cabe;

`ifdef FN_DIV_SIGNO_EN
    logic neg_q, neg_q_sig, neg_r, neg_r_sig;
    logic a_neg, b_neg;

    assign a_neg = signo & a[ANCHO-1];
    assign b_neg = signo & b[ANCHO-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
`else
    assign mag_a = a;
    assign mag_b = b;
`endif

    // Trial subtraction; the extra top bit of dif is the borrow.
    assign tanteo = {parcial, dividendo[ANCHO-1]};
    assign dif    = {1'b0, tanteo} - {2'b00, divisor};
    assign cabe   = ~dif[ANCHO+1];

    logic [1:0] unused_bits;
    assign unused_bits = {signo, dif[ANCHO]};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch.
        estado_sig    = estado;
        cuenta_sig    = cuenta;
        dividendo_sig = dividendo;
        divisor_sig   = divisor;
        parcial_sig   = parcial;
        ocupado_sig   = ocupado;
        listo_sig     = 1'b0;
        cociente_sig  = cociente;
        resto_sig     = resto;
`ifdef FN_DIV_SIGNO_EN
        neg_q_sig     = neg_q;
        neg_r_sig     = neg_r;
`endif

        unique case (estado)
            REPOSO: begin
                if (inicio) begin
                    estado_sig    = CALCULO;
                    cuenta_sig    = CW'(ANCHO);
                    dividendo_sig = mag_a;
                    divisor_sig   = mag_b;
                    parcial_sig   = '0;
                    ocupado_sig   = 1'b1;
`ifdef FN_DIV_SIGNO_EN
                    // A zero divisor keeps the all-ones quotient uncorrected.
                    neg_q_sig     = (a_neg ^ b_neg) & (b != '0);
                    neg_r_sig     = a_neg;
`endif
                end
            end

            CALCULO: begin
                parcial_sig   = cabe ? dif[ANCHO-1:0] : tanteo[ANCHO-1:0];
                dividendo_sig = {dividendo[ANCHO-2:0], cabe};
                cuenta_sig    = cuenta - CW'(1);
                if (cuenta == CW'(1)) begin
                    estado_sig = AJUSTE;
                end
            end

            AJUSTE: begin
`ifdef FN_DIV_SIGNO_EN
                cociente_sig = neg_q ? -dividendo : dividendo;
                resto_sig    = neg_r ? -parcial : parcial;
`else
                cociente_sig = dividendo;
                resto_sig    = parcial;
`endif
                listo_sig    = 1'b1;
                ocupado_sig  = 1'b0;
                estado_sig   = REPOSO;
            end

            default: estado_sig = REPOSO;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= REPOSO;
            cuenta    <= '0;
            dividendo <= '0;
            divisor   <= '0;
            parcial   <= '0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            cociente  <= '0;
            resto     <= '0;
`ifdef FN_DIV_SIGNO_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            estado    <= estado_sig;
            cuenta    <= cuenta_sig;
            dividendo <= dividendo_sig;
            divisor   <= divisor_sig;
            parcial   <= parcial_sig;
            ocupado   <= ocupado_sig;
            listo     <= listo_sig;
            cociente  <= cociente_sig;
            resto     <= resto_sig;
`ifdef FN_DIV_SIGNO_EN
            neg_q     <= neg_q_sig;
            neg_r     <= neg_r_sig;
`endif
        end
    end

endmodule

// File: tb/tb_fn_division_seq.sv
// Self-checking bench for fn_division_seq: arithmetic reference model compared every cycle,
// plus directed literal cases. Signed expectations follow FN_DIV_SIGNO_EN.
module tb_fn_division_seq;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         inicio = 1'b0;
    logic         signo = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ocupado, listo;
    logic [W-1:0] cociente, resto;

    int n_checks = 0;
    int n_errors = 0;

    fn_division_seq #(.ANCHO(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .signo    (signo),
        .a        (a),
        .b        (b),
        .ocupado  (ocupado),
        .listo    (listo),
        .cociente (cociente),
        .resto    (resto)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    function automatic res_t ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t res;
        logic en_signo;
`ifdef FN_DIV_SIGNO_EN
        en_signo = s;
`else
        en_signo = 1'b0 & s;
`endif
        if (y == '0) begin
            res.q = '1;
            res.r = x;
        end else if (en_signo && x == MIN && y == '1) begin
            res.q = x;
            res.r = '0;
        end else if (en_signo) begin
            res.q = W'($signed(x) / $signed(y));
            res.r = W'($signed(x) % $signed(y));
        end else begin
            res.q = x / y;
            res.r = x % y;
        end
        return res;
    endfunction

    // Reference model: a job accepted at edge N completes at edge N+W+1.
    int           cyc = 0;
    int           m_done_at = 0;
    logic         chk_en = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_listo = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    res_t         pend = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            chk_en  <= 1'b1;
            m_busy  <= 1'b0;
            m_listo <= 1'b0;
            m_q     <= '0;
            m_r     <= '0;
        end else begin
            m_listo <= 1'b0;
            if (m_busy && cyc == m_done_at) begin
                m_busy  <= 1'b0;
                m_listo <= 1'b1;
                m_q     <= pend.q;
                m_r     <= pend.r;
            end else if (!m_busy && inicio) begin
                m_busy    <= 1'b1;
                m_done_at <= cyc + W + 1;
                pend      <= ref_div(signo, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_listo", W'(listo), W'(m_listo));
            check("model_ocupado", W'(ocupado), W'(m_busy));
            check("model_cociente", cociente, m_q);
            check("model_resto", resto, m_r);
        end
    end

    task automatic wait_listo(output int lat);
        lat = -1;
        for (int k = 1; k <= W + 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (listo) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic op(input string nm, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        @(posedge clk);
        #1;
        signo = s; a = x; b = y; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_listo(lat);
        check({nm, "_latency"}, W'(lat), W'(W + 1));
        check({nm, "_cociente"}, cociente, eq);
        check({nm, "_resto"}, resto, er);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return MIN;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int pulses;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_ocupado", W'(ocupado), '0);
        check("reset_listo", W'(listo), '0);
        check("reset_cociente", cociente, '0);
        check("reset_resto", resto, '0);

        op("unsigned", 1'b0, W'(100), W'(7), W'(14), W'(2));
        op("divzero", 1'b0, 32'h1234_5678, '0, 32'hFFFF_FFFF, 32'h1234_5678);
`ifdef FN_DIV_SIGNO_EN
        op("signed", 1'b1, 32'hFFFF_FFF9, W'(2), 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        op("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, '0);
        op("divzero_neg", 1'b1, 32'hFFFF_FFF0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
`else
        op("signed", 1'b1, 32'hFFFF_FFF9, W'(2), 32'h7FFF_FFFC, W'(1));
        op("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '0, 32'h8000_0000);
`endif

        // Second start while busy must be ignored.
        @(posedge clk);
        #1;
        signo = 1'b0; a = W'(1000); b = W'(7); inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = W'(5); b = W'(1); inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0; a = '0; b = '0;
        wait_listo(lat);
        check("busy_latency", W'(lat), W'(W - 4));
        check("busy_cociente", cociente, W'(142));
        check("busy_resto", resto, W'(6));
        pulses = 0;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            if (listo) pulses++;
        end
        check("busy_no_second_listo", W'(pulses), '0);

        // Reset mid-operation aborts it.
        @(posedge clk);
        #1;
        a = W'(100); b = W'(7); inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ocupado", W'(ocupado), '0);
        check("abort_listo", W'(listo), '0);
        check("abort_cociente", cociente, '0);
        check("abort_resto", resto, '0);
        pulses = 0;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            if (listo) pulses++;
        end
        check("abort_no_listo", W'(pulses), '0);

        // Reset wins over a simultaneous start.
        @(posedge clk);
        #1;
        reset = 1'b1; inicio = 1'b1; a = W'(9); b = W'(3);
        @(posedge clk);
        #1;
        reset = 1'b0; inicio = 1'b0;
        @(negedge clk);
        check("reset_priority_ocupado", W'(ocupado), '0);

        // Back-to-back: start held during the listo cycle.
        @(posedge clk);
        #1;
        signo = 1'b0; a = W'(100); b = W'(7); inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_listo(lat);
        check("b2b_first_cociente", cociente, W'(14));
        check("b2b_first_resto", resto, W'(2));
        a = W'(9); b = W'(3); inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_listo(lat);
        check("b2b_latency", W'(lat), W'(W + 1));
        check("b2b_cociente", cociente, W'(3));
        check("b2b_resto", resto, '0);

        // Random traffic: starts at any time, occasional resets; the model checks every cycle.
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            reset  = ($urandom_range(0, 599) == 0);
            inicio = ($urandom_range(0, 2) == 0);
            signo  = 1'($urandom);
            a      = pick();
            b      = pick();
        end
        @(posedge clk);
        #1;
        reset = 1'b0; inicio = 1'b0;
        repeat (W + 5) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
